demux32bit_1_2_buf: RTL and testbench

Buffered 1-to-2 demultiplexer for 32-bit words. It is the distribution counterpart of the datapath 2:1 selector: one valid/ready input stream is steered by a per-word select bit into one of two independently back-pressured output streams. Each output has its own small FIFO, so a stalled consumer never blocks words bound for the other output. It sits between a producer (write-back or memory-return path) and two consumers in the MIPS datapath.

---
 rtl/demux32bit_1_2_buf.sv | 142 ++++++++++++++
 tb/tb_demux32bit_1_2_buf.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/demux32bit_1_2_buf.sv
// Buffered 1-to-2 demultiplexer: one valid/ready stream steered per word into two FIFO-backed outputs.
// Optional per-destination accept counters when DEMUX_STATS_EN is defined.
module demux32bit_1_2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
`ifdef DEMUX_STATS_EN
  output logic [15:0]      stat0_count,
  output logic [15:0]      stat1_count,
`endif
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] mem_d [2][DEPTH];
  logic [AW-1:0]    wptr_q [2];
  logic [AW-1:0]    wptr_d [2];
  logic [AW-1:0]    rptr_q [2];
  logic [AW-1:0]    rptr_d [2];
  logic [CW-1:0]    count_q [2];
  logic [CW-1:0]    count_d [2];
  logic [1:0]       push_s;
  logic [1:0]       pop_s;
  logic [1:0]       out_ready_s;
  logic             full0_s;
  logic             full1_s;

  assign out_ready_s = {out1_ready, out0_ready};
  assign full0_s     = (count_q[0] == FULL_CNT);
  assign full1_s     = (count_q[1] == FULL_CNT);

  // A full destination stalls the input even if it is popped this cycle.
  assign in_ready = rst_n && (in_sel ? !full1_s : !full0_s);

  assign out0_valid = (count_q[0] != {CW{1'b0}});
  assign out1_valid = (count_q[1] != {CW{1'b0}});
  assign out0_data  = out0_valid ? mem_q[0][rptr_q[0]] : {WIDTH{1'b0}};
  assign out1_data  = out1_valid ? mem_q[1][rptr_q[1]] : {WIDTH{1'b0}};

  // Next-state for both FIFOs: handshakes, pointer advance, occupancy.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    push_s  = 2'b00;
    pop_s   = 2'b00;
    for (int k = 0; k < 2; k++) begin
      push_s[k] = in_valid && in_ready && ((k == 1) ? in_sel : !in_sel);
      pop_s[k]  = (count_q[k] != {CW{1'b0}}) && out_ready_s[k];
      if (push_s[k]) begin
        mem_d[k][wptr_q[k]] = in_data;
        wptr_d[k]           = wptr_q[k] + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wptr_d[k] = wptr_q[k];
      end
      if (pop_s[k]) begin
        rptr_d[k] = rptr_q[k] + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rptr_d[k] = rptr_q[k];
      end
      case ({push_s[k], pop_s[k]})
        2'b10:   count_d[k] = count_q[k] + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_d[k] = count_q[k] - {{(CW-1){1'b0}}, 1'b1};
        default: count_d[k] = count_q[k];
      endcase
    end
  end

  // Pointer and occupancy registers; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        wptr_q[k]  <= {AW{1'b0}};
        rptr_q[k]  <= {AW{1'b0}};
        count_q[k] <= {CW{1'b0}};
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: reads are gated by occupancy.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef DEMUX_STATS_EN
  logic [15:0] stat0_q;
  logic [15:0] stat0_d;
  logic [15:0] stat1_q;
  logic [15:0] stat1_d;

  // Saturating accept counters, one per destination.
  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (push_s[0] && (stat0_q != 16'hFFFF)) begin
      stat0_d = stat0_q + 16'd1;
    end else begin
      stat0_d = stat0_q;
    end
    if (push_s[1] && (stat1_q != 16'hFFFF)) begin
      stat1_d = stat1_q + 16'd1;
    end else begin
      stat1_d = stat1_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat0_q <= 16'd0;
      stat1_q <= 16'd0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign stat0_count = stat0_q;
  assign stat1_count = stat1_q;
`endif

endmodule

// File: tb/tb_demux32bit_1_2_buf.sv
// Directed self-checking bench for demux32bit_1_2_buf (define DEMUX_STATS_EN to cover the counters).
module tb_demux32bit_1_2_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [31:0] in_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
`ifdef DEMUX_STATS_EN
  logic [15:0] stat0_count;
  logic [15:0] stat1_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  demux32bit_1_2_buf #(.WIDTH(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
`ifdef DEMUX_STATS_EN
    .stat0_count(stat0_count),
    .stat1_count(stat1_count),
`endif
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the producer side and let in_ready settle.
  task automatic drive(input logic v, input logic s, input logic [31:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b1, 1'b0, 32'hDEAD_BEEF);
    check("rst_in_ready_pre", {31'd0, in_ready}, 32'd0);

    // Reset held two cycles with a word offered.
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_v0", {31'd0, out0_valid}, 32'd0);
    check("rst_v1", {31'd0, out1_valid}, 32'd0);
    check("rst_d0", out0_data, 32'd0);
    check("rst_d1", out1_data, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
    tick();
    check("rst_nothing_v0", {31'd0, out0_valid}, 32'd0);
    check("rst_nothing_v1", {31'd0, out1_valid}, 32'd0);

    // Steering with both consumers ready.
    drive(1'b1, 1'b0, 32'd32);
    check("st_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("st_v0_a", {31'd0, out0_valid}, 32'd1);
    check("st_d0_a", out0_data, 32'd32);
    check("st_v1_a", {31'd0, out1_valid}, 32'd0);
    drive(1'b1, 1'b1, 32'd35);
    tick();
    check("st_v0_b", {31'd0, out0_valid}, 32'd0);
    check("st_v1_b", {31'd0, out1_valid}, 32'd1);
    check("st_d1_b", out1_data, 32'd35);
    drive(1'b1, 1'b0, 32'd64);
    tick();
    check("st_d0_c", out0_data, 32'd64);
    check("st_v1_c", {31'd0, out1_valid}, 32'd0);
    drive(1'b0, 1'b1, 32'h5555_5555);
    tick();
    check("st_v0_d", {31'd0, out0_valid}, 32'd0);
    check("st_v1_d", {31'd0, out1_valid}, 32'd0);

    // Back-pressure on out0 while out1 keeps flowing.
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'd2);
    check("bp_ready_one", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'd3);
    check("bp_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 1'b1, 32'd99);
    check("bp_other_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_d1", out1_data, 32'd99);
    check("bp_d0_hold", out0_data, 32'd1);
    out0_ready = 1'b1;
    drive(1'b1, 1'b0, 32'd3);
    check("bp_full_popping", {31'd0, in_ready}, 32'd0);
    tick();
    check("bp_d0_2", out0_data, 32'd2);
    check("bp_reready", {31'd0, in_ready}, 32'd1);
    check("bp_v1_drained", {31'd0, out1_valid}, 32'd0);
    tick();
    check("bp_d0_3", out0_data, 32'd3);
    drive(1'b0, 1'b0, 32'd0);
    tick();
    check("bp_v0_empty", {31'd0, out0_valid}, 32'd0);

    // Push and pop every cycle on out1: wraps with no bubble.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 32'd100 + 32'(i));
      check("pp_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("pp_v1", {31'd0, out1_valid}, 32'd1);
      check("pp_d1", out1_data, 32'd100 + 32'(i));
    end
    drive(1'b0, 1'b0, 32'd0);
    tick();
    check("pp_v1_end", {31'd0, out1_valid}, 32'd0);

    // Pops into an empty FIFO are ignored.
    tick();
    drive(1'b1, 1'b0, 32'd42);
    tick();
    check("uf_d0", out0_data, 32'd42);
    drive(1'b0, 1'b0, 32'd0);
    tick();
    check("uf_v0", {31'd0, out0_valid}, 32'd0);

    // Reset mid-stream with out0 full.
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'd5);
    tick();
    drive(1'b1, 1'b0, 32'd6);
    tick();
    check("mr_full", {31'd0, out0_valid}, 32'd1);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'd7);
    check("mr_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    out0_ready = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
    check("mr_v0", {31'd0, out0_valid}, 32'd0);
    check("mr_d0", out0_data, 32'd0);
    check("mr_v1", {31'd0, out1_valid}, 32'd0);
    tick();
    check("mr_v0_after", {31'd0, out0_valid}, 32'd0);

`ifdef DEMUX_STATS_EN
    check("stat0_reset", {16'd0, stat0_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'd10 + 32'(i));
      tick();
    end
    drive(1'b1, 1'b1, 32'd20);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    check("stat0_3", {16'd0, stat0_count}, 32'd3);
    check("stat1_1", {16'd0, stat1_count}, 32'd1);
    tick();
    force dut.stat0_q = 16'hFFFE;
    #1;
    release dut.stat0_q;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'd30 + 32'(i));
      tick();
    end
    drive(1'b0, 1'b0, 32'd0);
    check("stat0_sat", {16'd0, stat0_count}, 32'h0000_FFFF);
    check("stat1_hold", {16'd0, stat1_count}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
